// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the instruction fetch front-end.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_INCR   = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO; flush takes priority over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  entry_t                       wdata_i,
    output entry_t                       head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count gates whether any entry is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front-end: owns the fetch PC, fills the prefetch FIFO
// from combinational instruction memory and hands words to decode.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned          FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_data_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    logic [ADDR_WIDTH-1:0]           fetch_pc_q, fetch_pc_d;
    logic                            push, pop;
    logic                            fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
    entry_t                          fifo_head, fifo_wdata;

    assign imem_addr_o = {fetch_pc_q[ADDR_WIDTH-1:2], 2'b00};

    assign pop  = instr_valid_o && instr_ready_i;
    assign push = !rst && !redirect_i
                  && ((fifo_count < ($clog2(FIFO_DEPTH+1))'(FIFO_DEPTH)) || pop);

    assign fifo_wdata = '{instr: imem_data_i, pc: imem_addr_o};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_INCR);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (fifo_wdata),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A push into a full FIFO is only legal alongside a pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && fifo_full && !pop));
        end
    end

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_empty ? DATA_WIDTH'(NOP_INSTR) : fifo_head.instr;
    assign pc_o          = fifo_empty ? '0 : fifo_head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch against a queue-based reference model.
module tb_instr_fetch;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_ready_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr_o   (imem_addr_o),
        .imem_data_i   (imem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    // Memory contents are a fixed scramble of the address so instr and pc differ.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    assign imem_data_i = mem_word(imem_addr_o);

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    // Reference model: PCs currently buffered, plus the next fetch PC.
    logic [31:0] m_q[$];
    logic [31:0] m_pc;

    task automatic step(input logic r, input logic red, input logic [31:0] tgt, input logic rdy);
        bit          do_pop;
        bit          do_push;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        rst           = r;
        redirect_i    = red;
        redirect_pc_i = tgt;
        instr_ready_i = rdy;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_pc = RST_PC;
        end else if (red) begin
            m_q.delete();
            m_pc = tgt & ~32'h3;
        end else begin
            do_pop  = (m_q.size() > 0) && rdy;
            do_push = (m_q.size() < DEPTH) || do_pop;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(m_pc & ~32'h3);
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
        exp_pc    = (m_q.size() > 0) ? m_q[0] : 32'h0;
        exp_instr = (m_q.size() > 0) ? mem_word(m_q[0]) : NOP;
        check("valid", 32'(instr_valid_o), 32'(m_q.size() > 0));
        check("pc", pc_o, exp_pc);
        check("instr", instr_o, exp_instr);
        check("addr", imem_addr_o, m_pc & ~32'h3);
    endtask

    initial begin
        rst           = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        m_pc          = RST_PC;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_valid", 32'(instr_valid_o), 32'h0);
        check("rst_instr", instr_o, NOP);
        check("rst_addr", imem_addr_o, RST_PC);

        // Streaming with ready held high
        step(0, 0, 0, 1);
        check("first_valid", 32'(instr_valid_o), 32'h1);
        check("first_pc", pc_o, 32'h0);
        for (int unsigned i = 0; i < 3; i++) step(0, 0, 0, 1);
        check("stream_pc", pc_o, 32'hC);

        // Back-pressure fills the FIFO
        step(1, 0, 0, 0);
        for (int unsigned i = 0; i < 6; i++) step(0, 0, 0, 0);
        check("full_addr", imem_addr_o, 32'h8);
        check("full_pc", pc_o, 32'h0);
        step(0, 0, 0, 1);
        check("resume_pc", pc_o, 32'h4);

        // Redirect flushes 0x4/0x8
        step(0, 1, 32'h100, 0);
        check("redir_valid", 32'(instr_valid_o), 32'h0);
        check("redir_addr", imem_addr_o, 32'h100);
        step(0, 0, 0, 1);
        check("redir_pc", pc_o, 32'h100);
        for (int unsigned i = 0; i < 3; i++) step(0, 0, 0, 1);

        // Misaligned target
        step(0, 1, 32'h203, 1);
        step(0, 0, 0, 1);
        check("misal_pc", pc_o, 32'h200);

        // Address wrap
        step(0, 1, 32'hFFFF_FFF8, 1);
        step(0, 0, 0, 1);
        check("wrap_pc0", pc_o, 32'hFFFF_FFF8);
        step(0, 0, 0, 1);
        check("wrap_pc1", pc_o, 32'hFFFF_FFFC);
        step(0, 0, 0, 1);
        check("wrap_pc2", pc_o, 32'h0);
        step(0, 0, 0, 1);
        check("wrap_pc3", pc_o, 32'h4);

        // Reset beats a simultaneous redirect with a full FIFO
        for (int unsigned i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 1, 32'h400, 1);
        check("rst_redir_valid", 32'(instr_valid_o), 32'h0);
        check("rst_redir_instr", instr_o, NOP);
        check("rst_redir_addr", imem_addr_o, RST_PC);
        step(0, 0, 0, 1);
        check("rst_resume_pc", pc_o, RST_PC);

        // Random traffic, including back-to-back redirects
        for (int unsigned i = 0; i < 600; i++) begin
            logic        r;
            logic        red;
            logic [31:0] tgt;
            logic        rdy;
            r   = ($urandom_range(0, 59) == 0);
            red = ($urandom_range(0, 7) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom();
            rdy = ($urandom_range(0, 2) != 0);
            step(r, red, tgt, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch front-end, the reader side of the instruction memory.
- Owns the fetch PC and drives a word-aligned address to the instruction memory every cycle.
- Captures the combinational read data, tagged with its PC, into a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Handles control-flow redirects from execute by flushing the FIFO and restarting at the new PC.

Parameters:
- ADDR_WIDTH, 32, width of the PC and the memory address.
- DATA_WIDTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr_o  out  ADDR_WIDTH  fetch address to the instruction memory; bits [1:0] always 0.
- imem_data_i  in  DATA_WIDTH  combinational read data for imem_addr_o, valid in the same cycle.
- redirect_i  in  1  redirect request from execute (branch, jump, trap).
- redirect_pc_i  in  ADDR_WIDTH  redirect target; bits [1:0] ignored and treated as 0.
- instr_valid_o  out  1  FIFO head holds a valid instruction.
- instr_ready_i  in  1  decode accepts the head this cycle.
- instr_o  out  DATA_WIDTH  head instruction; 32'h00000013 (NOP) when empty.
- pc_o  out  ADDR_WIDTH  PC of the head instruction; 0 when empty.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous, active-high.
- Reset values (rst high at an edge):
  - fetch_pc = RESET_PC.
  - FIFO empty: pointers 0, count 0.
  - instr_valid_o = 0, instr_o = NOP, pc_o = 0.
  - imem_addr_o = RESET_PC with [1:0] forced to 0.
  - rst overrides redirect_i, pop and push in the same cycle.
- Address: imem_addr_o = {fetch_pc[ADDR_WIDTH-1:2], 2'b00}, combinational from the register.
- pop = instr_valid_o && instr_ready_i.
- push = !rst && !redirect_i && (count < FIFO_DEPTH || pop).
  - Pushing while full is legal only when a pop happens in the same cycle.
- On push:
  - Write entry {imem_data_i, imem_addr_o} at the tail.
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^ADDR_WIDTH (0xFFFFFFFC -> 0x0).
- No push (FIFO full without pop): fetch_pc holds, and imem_addr_o repeats the same address.
- Count update: count += push - pop. Simultaneous push and pop keeps count, and both pointers advance.
- Latency:
  - An instruction fetched in cycle N is visible on instr_o/pc_o with instr_valid_o = 1 in cycle N+1.
  - First valid output is in the second cycle after rst deasserts.
- Output is registered state only: no combinational path from imem_data_i or instr_ready_i to instr_o, pc_o or instr_valid_o.
- Redirect (redirect_i = 1, rst = 0), in the same edge:
  - FIFO flushed: count = 0, pointers reset.
  - fetch_pc <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00}.
  - No push; any pop that cycle is still counted as delivered.
  - Next cycle: instr_valid_o = 0 and imem_addr_o = new target.
  - The cycle after that: the target instruction is valid.
- Back-to-back redirects: the last one wins, and valid stays 0 until one cycle after redirect_i falls.
- Stability: while instr_valid_o = 1 and instr_ready_i = 0, instr_o and pc_o hold stable, except when a redirect flushes the FIFO.
- No state machine beyond the FIFO count and fetch_pc; fetch runs continuously whenever space exists.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR = 32'h00000013.
  - Typedef fetch_entry_t, a packed struct {instr, pc}.
  - Constant PC_INCR = 4.
- Sub-module fetch_fifo:
  - Synchronous FIFO parameterised by DEPTH and entry type.
  - Ports: push, pop, flush, full, empty, head, count.
  - Flush has priority over push and pop.
- instr_fetch owns the PC, push/pop logic and output defaults.

Test Plan:
1. Reset, then rst low; memory returns addr as data; ready = 1 throughout -> valid rises 2nd cycle after reset; pc_o sequence 0x0, 0x4, 0x8, … with instr_o == pc_o, one per cycle.
2. ready = 0 for 5 cycles after first valid -> FIFO fills to 2; imem_addr_o holds at 0x8; instr_o/pc_o stay 0x0. Then ready = 1 -> deliver 0x0, 0x4, 0x8 in order with no gaps or duplicates.
3. Redirect to 0x100 while FIFO holds 0x4, 0x8 -> next cycle valid = 0 and imem_addr_o = 0x100; following cycle pc_o = 0x100; 0x4 and 0x8 are never delivered.
4. Redirect to 0x203 (misaligned) -> fetch restarts at 0x200; pc_o = 0x200.
5. Redirect to 0xFFFFFFF8 with ready = 1 -> pc_o sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
6. Assert rst mid-stream with FIFO full and redirect_i = 1 in the same cycle -> next cycle valid = 0, instr_o = 0x00000013, imem_addr_o = RESET_PC; delivery resumes from RESET_PC.
